// File: rtl/comb_logic_result_fifo.sv
// comb_logic_result_fifo: packs ALU results by instruction into a valid/ready FIFO; COMB_RESULT_FIFO_CNT_EN adds per-instruction push counters
module comb_logic_result_fifo #(
  parameter int Dwidth = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int RW = 2*Dwidth+1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        Inst,
  input  logic [Dwidth-1:0] sum,
  input  logic              Cout,
  input  logic [2*Dwidth-1:0] Prod,
  input  logic              XEGY,
  input  logic [Dwidth-1:0] Sel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_inst,
  output logic [RW-1:0]     out_data,
`ifdef COMB_RESULT_FIFO_CNT_EN
  input  logic [1:0]        op_cnt_sel,
  output logic [15:0]       op_cnt,
`endif
  output logic [AW:0]       count
);
  logic [RW+1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic push, pop;
  logic [RW-1:0] packed_d;
  assign in_ready = cnt_q != (AW+1)'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign {out_inst, out_data} = out_valid ? mem_q[rd_q] : '0;
  assign count = cnt_q;
  // select only the result field matching the instruction so stale ALU outputs never leak
  always_comb
    packed_d = Inst == 2'd0 ? RW'({Cout, sum}) :
               Inst == 2'd1 ? RW'(Prod) :
               Inst == 2'd2 ? RW'(XEGY) : RW'(Sel_out);
  // storage needs no reset; entries are only visible once counted
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {Inst, packed_d};
  // pointers wrap naturally at AW bits; occupancy tracks push minus pop
  always_ff @(posedge clk)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
`ifdef COMB_RESULT_FIFO_CNT_EN
  logic [15:0] opc_q [4];
  assign op_cnt = opc_q[op_cnt_sel];
  // saturating push counter per instruction
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 4; i++) opc_q[i] <= '0;
    else if (push && opc_q[Inst] != 16'hFFFF) opc_q[Inst] <= opc_q[Inst] + 16'd1;
`endif
endmodule

// File: tb/tb_comb_logic_result_fifo.sv
// tb_comb_logic_result_fifo: vector table plus queue-model random checks for the result FIFO
module tb_comb_logic_result_fifo;
  localparam int DW = 4, DEPTH = 4, AW = 2, RW = 2*DW+1;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, in_ready, out_valid;
  logic [1:0] Inst = 0, out_inst;
  logic [DW-1:0] sum = 0, Sel_out = 0;
  logic Cout = 0, XEGY = 0;
  logic [2*DW-1:0] Prod = 0;
  logic [RW-1:0] out_data;
  logic [AW:0] count;
`ifdef COMB_RESULT_FIFO_CNT_EN
  logic [1:0] op_cnt_sel = 0;
  logic [15:0] op_cnt;
  int opc[4];
`endif
  typedef struct {
    logic [1:0] inst;
    logic [DW-1:0] sum;
    logic cout;
    logic [2*DW-1:0] prod;
    logic xegy;
    logic [DW-1:0] sel;
    logic [RW-1:0] exp;
  } vec_t;
  typedef struct {logic [1:0] inst; logic [RW-1:0] data;} ent_t;
  vec_t tv[8];
  ent_t q[$];
  int checks = 0, errors = 0;

  comb_logic_result_fifo #(.Dwidth(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Inst(Inst),
    .sum(sum), .Cout(Cout), .Prod(Prod), .XEGY(XEGY), .Sel_out(Sel_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_data(out_data),
`ifdef COMB_RESULT_FIFO_CNT_EN
    .op_cnt_sel(op_cnt_sel), .op_cnt(op_cnt),
`endif
    .count(count));

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pack(logic [1:0] i);
    int v;
    case (i)
      2'd0: v = int'(Cout) * (1 << DW) + int'(sum);
      2'd1: v = int'(Prod);
      2'd2: v = int'(XEGY);
      default: v = int'(Sel_out);
    endcase
    return RW'(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(string nm);
    chk({nm, " count"}, 32'(count), 32'(q.size()));
    chk({nm, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({nm, " in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    chk({nm, " out_data"}, 32'(out_data), q.size() > 0 ? 32'(q[0].data) : 0);
    chk({nm, " out_inst"}, 32'(out_inst), q.size() > 0 ? 32'(q[0].inst) : 0);
  endtask

  task automatic cyc();
    bit push, pop;
    ent_t e;
    push = in_valid && q.size() < DEPTH;
    pop = out_ready && q.size() > 0;
    e.inst = Inst;
    e.data = pack(Inst);
    @(posedge clk);
    if (rst) begin
      q.delete();
`ifdef COMB_RESULT_FIFO_CNT_EN
      opc = '{0, 0, 0, 0};
`endif
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
`ifdef COMB_RESULT_FIFO_CNT_EN
      if (push && opc[e.inst] < 65535) opc[e.inst]++;
`endif
    end
    #1;
  endtask

  task automatic drive(vec_t v);
    Inst = v.inst; sum = v.sum; Cout = v.cout; Prod = v.prod; XEGY = v.xegy; Sel_out = v.sel;
  endtask

  task automatic mux_val(int v);
    Inst = 2'd3; Sel_out = DW'(v); sum = 4'hF; Cout = 1; Prod = 8'hFF; XEGY = 1;
  endtask

  initial begin
    tv[0] = '{2'd0, 4'hF, 1'b1, 8'h5A, 1'b1, 4'h6, 9'h01F};
    tv[1] = '{2'd1, 4'h3, 1'b1, 8'hE1, 1'b1, 4'hF, 9'h0E1};
    tv[2] = '{2'd2, 4'hF, 1'b1, 8'hFF, 1'b1, 4'hF, 9'h001};
    tv[3] = '{2'd3, 4'h5, 1'b1, 8'hFF, 1'b1, 4'hA, 9'h00A};
    tv[4] = '{2'd2, 4'hF, 1'b1, 8'hFF, 1'b0, 4'hF, 9'h000};
    tv[5] = '{2'd0, 4'h0, 1'b0, 8'hFF, 1'b1, 4'hF, 9'h000};
    tv[6] = '{2'd1, 4'hF, 1'b1, 8'h00, 1'b1, 4'hF, 9'h000};
    tv[7] = '{2'd0, 4'h7, 1'b0, 8'hC3, 1'b1, 4'h9, 9'h007};
    rst = 1; cyc(); cyc(); rst = 0;
    chk("reset count", 32'(count), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset out_inst", 32'(out_inst), 0);
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin drive(tv[i]); cyc(); end
    in_valid = 0;
    chk("fill count", 32'(count), 4);
    chk("fill in_ready", 32'(in_ready), 0);
    cyc();
    chk("stall hold data", 32'(out_data), 32'(tv[0].exp));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order data %0d", i), 32'(out_data), 32'(tv[i].exp));
      chk($sformatf("order inst %0d", i), 32'(out_inst), 32'(tv[i].inst));
      out_ready = 1; cyc(); out_ready = 0;
    end
    chk("drained valid", 32'(out_valid), 0);
    for (int i = 4; i < 8; i++) begin
      drive(tv[i]); in_valid = 1; cyc(); in_valid = 0;
      chk($sformatf("vec data %0d", i), 32'(out_data), 32'(tv[i].exp));
      chk($sformatf("vec inst %0d", i), 32'(out_inst), 32'(tv[i].inst));
      out_ready = 1; cyc(); out_ready = 0;
    end
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin mux_val(i + 1); cyc(); end
    mux_val(9); out_ready = 1; cyc();
    chk("full pop no push count", 32'(count), 3);
    chk_model("full pop");
    mux_val(7); out_ready = 0; cyc();
    chk("refill count", 32'(count), 4);
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin chk_model("overflow drain"); cyc(); end
    chk("overflow drained", 32'(count), 0);
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin mux_val(i + 11); cyc(); end
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      mux_val(i); cyc();
      chk("pushpop count", 32'(count), 2);
      chk_model("pushpop");
    end
    in_valid = 0; out_ready = 0;
    rst = 1; cyc(); rst = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin mux_val(i + 2); cyc(); end
    chk("pre-reset count", 32'(count), 3);
    rst = 1; out_ready = 1; cyc(); rst = 0; out_ready = 0;
    chk("mid reset count", 32'(count), 0);
    chk("mid reset valid", 32'(out_valid), 0);
    mux_val(6); cyc(); in_valid = 0;
    chk("post reset data", 32'(out_data), 9'h006);
    chk_model("post reset");
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 63) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      Inst = 2'($urandom); sum = DW'($urandom); Cout = 1'($urandom);
      Prod = (2*DW)'($urandom); XEGY = 1'($urandom); Sel_out = DW'($urandom);
      cyc();
      chk_model("random");
`ifdef COMB_RESULT_FIFO_CNT_EN
      op_cnt_sel = 2'($urandom); #1;
      chk("random op_cnt", 32'(op_cnt), 32'(opc[op_cnt_sel]));
`endif
    end
    rst = 0; in_valid = 0; out_ready = 0;
`ifdef COMB_RESULT_FIFO_CNT_EN
    rst = 1; cyc(); rst = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin drive(tv[0]); cyc(); end
    drive(tv[1]); cyc(); in_valid = 0;
    op_cnt_sel = 0; #1; chk("op_cnt add", 32'(op_cnt), 3);
    op_cnt_sel = 1; #1; chk("op_cnt mul", 32'(op_cnt), 1);
    in_valid = 1; drive(tv[0]);
    for (int i = 0; i < 70000; i++) cyc();
    in_valid = 0;
    op_cnt_sel = 0; #1; chk("op_cnt saturate", 32'(op_cnt), 32'hFFFF);
    op_cnt_sel = 1; #1; chk("op_cnt mul kept", 32'(op_cnt), 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
